// File: rtl/simon_pkg.sv
// simon_pkg
// Shared types and default sizing for the Simon game datapath. The sequence
// generator, the game FSM and seq_verify all import this package so that the
// button count and maximum round length agree everywhere.
//
// Contents:
//   DEFAULT_NUM_BUTTONS  number of buttons / colours
//   DEFAULT_MAX_LEN      longest round the segment store can hold
//   fail_reason_e        why a round was failed (reported to the game FSM)
//   verify_state_e       state encoding of the seq_verify FSM
package simon_pkg;

   localparam int DEFAULT_NUM_BUTTONS = 4;
   localparam int DEFAULT_MAX_LEN     = 32;

   typedef enum logic [2:0] {
      REASON_NONE    = 3'd0,
      REASON_WRONG   = 3'd1,
      REASON_MULTI   = 3'd2,
      REASON_TIMEOUT = 3'd3,
      REASON_BAD_LEN = 3'd4
   } fail_reason_e;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_PRESS   = 2'd1,
      WAIT_RELEASE = 2'd2,
      RESULT       = 2'd3
   } verify_state_e;

endpackage

// File: rtl/seq_verify_press_detect.sv
// press_detect
// Turns the debounced button levels into per-cycle press events for the
// sequence verifier.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   player_input  debounced button levels, one bit per button
//   rise          buttons that went from released to pressed this cycle
//   single_rise   exactly one new press and no other button held
//   multi         several new presses at once, or a new press while another
//                 button is still held
//   press_idx     index of the lowest rising button (meaningful with single_rise)
module press_detect #(
   parameter int NUM_BUTTONS = simon_pkg::DEFAULT_NUM_BUTTONS,
   parameter int IDX_W       = $clog2(NUM_BUTTONS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_BUTTONS-1:0] player_input,
   output logic [NUM_BUTTONS-1:0] rise,
   output logic                   single_rise,
   output logic                   multi,
   output logic [IDX_W-1:0]       press_idx
);

   localparam int CNT_W = $clog2(NUM_BUTTONS + 1);

   logic [NUM_BUTTONS-1:0] prevInput;
   logic [CNT_W-1:0]       riseCount;
   logic                   heldOther;

   // Remember last cycle's levels so a press is seen exactly once, on the
   // cycle its level first goes high. A button already held when a round
   // begins therefore never produces a rise until it is released and pressed
   // again.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prevInput <= '0;
      end else begin
         prevInput <= player_input;
      end
   end

   // Classify this cycle's activity. A press only counts as clean when it is
   // the only rising bit and nothing else is being held down; any other
   // combination with at least one rise is a multi-press.
   always_comb begin
      rise      = player_input & ~prevInput;
      heldOther = |(player_input & ~rise);
      riseCount = '0;
      press_idx = '0;
      for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
         riseCount = riseCount + CNT_W'(rise[i]);
         if (rise[i]) begin
            press_idx = IDX_W'(i);
         end
      end
      multi       = (riseCount > CNT_W'(1)) || ((riseCount != '0) && heldOther);
      single_rise = (riseCount == CNT_W'(1)) && !heldOther;
   end

endmodule

// File: rtl/seq_verify.sv
// seq_verify
// Walks the stored colour sequence of the current round one press at a time,
// compares each debounced press against the expected colour and reports a
// single-cycle pass or fail pulse (with a reason) to the game FSM.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   start         pulse: begin verifying a round (ignored while busy)
//   abort         synchronous return to IDLE without a result pulse
//   round_len     presses in this round, sampled on an accepted start
//   segment       expected colour index for every step, stable while busy
//   player_input  debounced button levels
//   busy          round in progress (through the result cycle)
//   pass, fail    one-cycle result pulses
//   fail_reason   fail_reason_e of the last failure, held until next start
//   step          index of the press currently expected
//
// Build option: define VERIFY_TIMEOUT_EN to fail a round with TIMEOUT after
// TIMEOUT_CYCLES idle cycles in WAIT_PRESS. Without it the verifier waits
// indefinitely for each press and TIMEOUT_CYCLES has no effect.
module seq_verify
   import simon_pkg::*;
#(
   parameter int NUM_BUTTONS    = DEFAULT_NUM_BUTTONS,
   parameter int MAX_LEN        = DEFAULT_MAX_LEN,
   parameter int TIMEOUT_CYCLES = 500_000_000,
   localparam int IDX_W         = $clog2(NUM_BUTTONS),
   localparam int LEN_W         = $clog2(MAX_LEN + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic                          abort,
   input  logic [LEN_W-1:0]              round_len,
   input  logic [MAX_LEN-1:0][IDX_W-1:0] segment,
   input  logic [NUM_BUTTONS-1:0]        player_input,
   output logic                          busy,
   output logic                          pass,
   output logic                          fail,
   output logic [2:0]                    fail_reason,
   output logic [LEN_W-1:0]              step
);

   localparam int STEP_IDX_W = $clog2(MAX_LEN);

   verify_state_e          state;
   verify_state_e          nextState;
   fail_reason_e           reasonQ;
   fail_reason_e           nextReason;
   logic [LEN_W-1:0]       lenQ;
   logic [LEN_W-1:0]       nextLen;
   logic [LEN_W-1:0]       nextStep;
   logic                   nextPass;
   logic                   nextFail;
   logic                   badLen;
   logic                   timeoutHit;
   logic [STEP_IDX_W-1:0]  stepIdx;
   logic [NUM_BUTTONS-1:0] rise;
   logic                   singleRise;
   logic                   multiPress;
   logic [IDX_W-1:0]       pressIdx;

   press_detect #(
      .NUM_BUTTONS (NUM_BUTTONS),
      .IDX_W       (IDX_W)
   ) u_press_detect (
      .clk          (clk),
      .rst          (rst),
      .player_input (player_input),
      .rise         (rise),
      .single_rise  (singleRise),
      .multi        (multiPress),
      .press_idx    (pressIdx)
   );

   assign stepIdx = step[STEP_IDX_W-1:0];

   // A round length of zero, or longer than the segment store, can never be
   // played; it is rejected straight away. The comparison is unsigned so any
   // encoding above MAX_LEN is caught.
   assign badLen = (round_len == '0) || (round_len > LEN_W'(MAX_LEN));

`ifdef VERIFY_TIMEOUT_EN
   localparam int TIMER_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TIMER_W-1:0] timer;

   // Idle-press timer. It restarts whenever the FSM enters a waiting state
   // and only advances while waiting for a press, so time spent holding a
   // button down never counts against the player.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer <= '0;
      end else if (nextState != state) begin
         timer <= '0;
      end else if (state == WAIT_PRESS) begin
         timer <= timer + TIMER_W'(1);
      end
   end

   assign timeoutHit = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
`else
   logic unusedTimeout;

   // Without the timeout build the verifier waits forever for each press.
   assign timeoutHit    = 1'b0;
   assign unusedTimeout = (TIMEOUT_CYCLES == 0);
`endif

   // Next-state and result decode. Abort overrides everything, including a
   // simultaneous start. In WAIT_PRESS a detected press takes priority over
   // the timeout firing in the same cycle. Pass/fail are decided here and
   // registered so they appear during the RESULT cycle.
   always_comb begin
      nextState  = state;
      nextReason = reasonQ;
      nextLen    = lenQ;
      nextStep   = step;
      nextPass   = 1'b0;
      nextFail   = 1'b0;
      if (abort) begin
         nextState = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  nextLen    = round_len;
                  nextStep   = '0;
                  nextReason = REASON_NONE;
                  if (badLen) begin
                     nextState  = RESULT;
                     nextFail   = 1'b1;
                     nextReason = REASON_BAD_LEN;
                  end else begin
                     nextState = WAIT_PRESS;
                  end
               end
            end
            WAIT_PRESS: begin
               if (multiPress) begin
                  nextState  = RESULT;
                  nextFail   = 1'b1;
                  nextReason = REASON_MULTI;
               end else if (singleRise) begin
                  if (pressIdx == segment[stepIdx]) begin
                     nextState = WAIT_RELEASE;
                  end else begin
                     nextState  = RESULT;
                     nextFail   = 1'b1;
                     nextReason = REASON_WRONG;
                  end
               end else if (timeoutHit) begin
                  nextState  = RESULT;
                  nextFail   = 1'b1;
                  nextReason = REASON_TIMEOUT;
               end
            end
            WAIT_RELEASE: begin
               if (rise != '0) begin
                  nextState  = RESULT;
                  nextFail   = 1'b1;
                  nextReason = REASON_MULTI;
               end else if (player_input == '0) begin
                  if (step == lenQ - LEN_W'(1)) begin
                     nextState = RESULT;
                     nextPass  = 1'b1;
                  end else begin
                     nextStep  = step + LEN_W'(1);
                     nextState = WAIT_PRESS;
                  end
               end
            end
            RESULT: begin
               nextState = IDLE;
            end
            default: begin
               nextState = IDLE;
            end
         endcase
      end
   end

   // State and output registers. busy follows the next state so it rises the
   // cycle after an accepted start and falls the cycle after RESULT. A reset
   // at any point returns everything to idle without a result pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         reasonQ <= REASON_NONE;
         lenQ    <= '0;
         step    <= '0;
         busy    <= 1'b0;
         pass    <= 1'b0;
         fail    <= 1'b0;
      end else begin
         state   <= nextState;
         reasonQ <= nextReason;
         lenQ    <= nextLen;
         step    <= nextStep;
         busy    <= (nextState != IDLE);
         pass    <= nextPass;
         fail    <= nextFail;
      end
   end

   assign fail_reason = reasonQ;

endmodule

// File: doc/seq_verify.md
# seq_verify

Sequential, parametrised successor to the combinational input checker. It walks the stored colour sequence for the current round one press at a time. It compares each debounced button press against the expected colour and reports a single-cycle pass or fail pulse with a failure reason to the game FSM. It sits between the button debouncers and the game FSM, reading the same segment store the sequence generator writes.

## Interface
- NUM_BUTTONS, 4: button/colour count; IDX_W = $clog2(NUM_BUTTONS)
- MAX_LEN, 32: maximum sequence length; LEN_W = $clog2(MAX_LEN+1)
- TIMEOUT_CYCLES, 500_000_000: idle cycles allowed per press (timeout build only)
- clk  in  1  single clock; one clock, all state on posedge clk
- rst  in  1  asynchronous, active-high reset
- start  in  1  pulse: begin verifying a round
- abort  in  1  synchronous: return to IDLE, no result pulse
- round_len  in  LEN_W  number of presses in this round, sampled on start
- segment  in  MAX_LEN x IDX_W  expected colour index per step; must be stable while busy
- player_input  in  NUM_BUTTONS  debounced, level, one bit per button
- busy  out  1  high from the cycle after an accepted start until the result cycle
- pass  out  1  one-cycle pulse: whole round entered correctly
- fail  out  1  one-cycle pulse: round failed
- fail_reason  out  3  fail_reason_e; held from fail until next accepted start
- step  out  LEN_W  index of the press currently expected

## Operation
- Edge detect: prev <= player_input every cycle; rise = player_input & ~prev.
- States: IDLE, WAIT_PRESS, WAIT_RELEASE, RESULT.
- IDLE: start latches len_q = round_len, step = 0, fail_reason = NONE, goes to WAIT_PRESS. If round_len == 0 or > MAX_LEN, go to RESULT with fail, BAD_LEN.
- start while busy is ignored.
- WAIT_PRESS:
  - A button already held on entry, with no rise, is ignored until released.
  - More than one rise bit in the same cycle, or a rise while another bit is held: fail, MULTI.
  - A single rise on bit k with k == segment[step]: go to WAIT_RELEASE.
  - A single rise on bit k with k != segment[step]: fail, WRONG.
- WAIT_RELEASE:
  - Any new rise: fail, MULTI.
  - player_input == 0 and step == len_q-1: pass.
  - player_input == 0 otherwise: step++, return to WAIT_PRESS.
- RESULT: asserts pass or fail for exactly one cycle, then goes to IDLE.
- abort from any state goes to IDLE. busy drops next cycle; no pulse; fail_reason unchanged.
- Simultaneous abort and start: abort wins.
- fail_reason_e: NONE=0, WRONG=1, MULTI=2, TIMEOUT=3, BAD_LEN=4.

## Timing
- Reset values: state IDLE, busy 0, pass 0, fail 0, fail_reason NONE, step 0, prev 0, timer 0.
- Reset mid-round: immediate return to IDLE, no pulse.
- All outputs registered.
- Decision latency: a rise seen at edge N changes state at edge N+1. pass/fail is high for the cycle following the final release or the error.
- Minimum round latency for len L with ideal one-cycle press/release: 2L+1 cycles from start to pass.
- step counts 0..len_q-1; it never wraps. len_q == MAX_LEN is legal.
- The round_len compare is unsigned over LEN_W bits.

## Configuration
- VERIFY_TIMEOUT_EN defined:
  - A cycle counter clears on entering WAIT_PRESS or WAIT_RELEASE.
  - It increments only in WAIT_PRESS.
  - Reaching TIMEOUT_CYCLES-1 with no rise gives fail, TIMEOUT.
  - A rise in that same cycle takes priority over the timeout.
- Undefined: no counter; WAIT_PRESS waits indefinitely; TIMEOUT is never reported; TIMEOUT_CYCLES is unused.

## Structure
- simon_pkg holds:
  - fail_reason_e
  - verify_state_e
  - default NUM_BUTTONS and MAX_LEN constants, shared with the sequence generator and game FSM
- One sub-module, press_detect: prev register, rise vector, single_rise flag, multi flag, encoded press index (IDX_W).
- seq_verify holds the FSM, step/len registers and the optional timer.

## Test plan
- len 3, segment {2,0,3}; press/release 2, 0, 3 -> pass pulse 1 cycle after final release; fail_reason NONE; busy low the cycle after.
- len 3, segment {2,0,3}; press 2, then 1 -> fail at step 1, fail_reason WRONG.
- Buttons 0 and 1 rise in the same cycle at step 0 -> fail, MULTI.
- start with round_len 0 -> fail, BAD_LEN, no WAIT_PRESS entered.
- VERIFY_TIMEOUT_EN with TIMEOUT_CYCLES=16; no press -> fail, TIMEOUT 16 cycles after entering WAIT_PRESS.
- abort at step 2 of 5, then rst asserted mid-round -> no pass/fail pulse; all outputs at reset values.
